// File: rtl/ternary_hazard_scoreboard.sv
// Ternary-register hazard scoreboard for an in-order pipeline.
// Tracks producers from EX through the forwarding stages, raises a load-use
// stall when a consumer in ID needs a result that does not exist yet, and
// registers a per-source forward select for the instruction entering EX.
//
// Trit encoding, two bits per trit: 2'b00 = 0, 2'b01 = +, 2'b10 = -.
//
// Flow control: id_valid qualifies ID for one cycle. While stall is high,
// ID is held and EX receives a bubble. flush kills ID and EX, and it wins
// over both stall and issue.

`ifndef T_ZERO
`define T_ZERO 2'b00
`endif

module ternary_hazard_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int ADDR_TRITS = 3,
    localparam int AW   = 2 * ADDR_TRITS,
    localparam int SELW = $clog2(FWD_STAGES + 1),
    localparam int LW   = $clog2(FWD_STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [NUM_SRC*AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]      id_src_used,
    input  logic [AW-1:0]           id_rd,
    input  logic                    id_reg_write,
    input  logic [LW-1:0]           id_lat,
    input  logic                    flush,
    output logic                    stall,
    output logic [NUM_SRC*SELW-1:0] ex_fwd_sel,
    output logic                    busy
);

    // Slot 0 is the producer in EX; slot k is the producer in forwarding stage k.
    logic [FWD_STAGES:0]         slot_valid;
    logic [FWD_STAGES:0][AW-1:0] slot_rd;
    logic [FWD_STAGES:0][LW-1:0] slot_lat;

    logic [NUM_SRC*SELW-1:0] sel_next;
    logic                    hazard;
    logic                    issue;
    logic [LW-1:0]           lat_clamped;

    // True when every trit of the address is zero (register R0).
    function automatic logic is_r0(input logic [AW-1:0] a);
        for (int t = 0; t < ADDR_TRITS; t++) begin
            if (a[2*t +: 2] != `T_ZERO) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Trit-by-trit address equality.
    function automatic logic trit_eq(input logic [AW-1:0] a, input logic [AW-1:0] b);
        for (int t = 0; t < ADDR_TRITS; t++) begin
            if (a[2*t +: 2] != b[2*t +: 2]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Per-source search for the youngest matching producer, forward select and hazard.
    always_comb begin
        logic          found;
        logic [AW-1:0] rs;
        sel_next = '0;
        hazard   = 1'b0;
        found    = 1'b0;
        rs       = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            found = 1'b0;
            rs    = id_rs[s*AW +: AW];
            if (id_src_used[s] && !is_r0(rs)) begin
                for (int j = 0; j < FWD_STAGES; j++) begin
                    if (!found && slot_valid[j] && trit_eq(slot_rd[j], rs)) begin
                        found                    = 1'b1;
                        sel_next[s*SELW +: SELW] = SELW'(j + 1);
                        if (int'(slot_lat[j]) > j + 1) hazard = 1'b1;
                    end
                end
            end
        end
    end

    // Latency clamp into 1..FWD_STAGES, and the issue condition for slot 0.
    always_comb begin
        lat_clamped = id_lat;
        if (id_lat == '0) lat_clamped = LW'(1);
        else if (int'(id_lat) > FWD_STAGES) lat_clamped = LW'(FWD_STAGES);
        stall = id_valid && !flush && hazard;
        issue = id_valid && id_reg_write && !stall && !flush && !is_r0(id_rd);
        busy  = |slot_valid;
    end

    // Producer shift pipeline and registered forward selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            slot_rd    <= '0;
            slot_lat   <= '0;
            ex_fwd_sel <= '0;
        end else begin
            slot_valid[0] <= issue;
            slot_rd[0]    <= issue ? id_rd : '0;
            slot_lat[0]   <= issue ? lat_clamped : '0;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_rd[k]    <= slot_rd[k-1];
                slot_lat[k]   <= slot_lat[k-1];
            end
            // The producer leaving EX is killed; older stages have committed.
            if (flush) slot_valid[1] <= 1'b0;
            ex_fwd_sel <= (id_valid && !stall && !flush) ? sel_next : '0;
        end
    end

endmodule

// File: doc/ternary_hazard_scoreboard.md
TERNARY_HAZARD_SCOREBOARD -- requirements
Module: ternary_hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2 (range 1..4): number of source operands checked per instruction.
REQ-002 SHALL have parameter FWD_STAGES, default 2 (range 1..6): number of forwarding stages after EX (stage 1 = MEM, stage 2 = WB, ...).
REQ-003 SHALL have parameter ADDR_TRITS, default 3: register address width in trits; AW = 2*ADDR_TRITS bits.
REQ-004 SHALL define derived SELW = clog2(FWD_STAGES+1) and LW = clog2(FWD_STAGES+1).
REQ-005 SHALL have ports, clock and reset first: clk in 1 clock; rst_n in 1 reset. One clock; reset is asynchronous and active-low.
REQ-006 id_valid in 1: a valid instruction is in ID.
REQ-007 id_rs in NUM_SRC*AW: source addresses; source s occupies bits [s*AW +: AW].
REQ-008 id_src_used in NUM_SRC: per-source "operand is read" flag.
REQ-009 id_rd in AW: destination address.
REQ-010 id_reg_write in 1: instruction writes id_rd.
REQ-011 id_lat in LW: producer latency, i.e. the first forwarding stage at which the result exists (1 = ALU at MEM, 2 = load at WB).
REQ-012 flush in 1: kill the instructions in ID and EX.
REQ-013 stall out 1: hold ID and insert a bubble into EX.
REQ-014 ex_fwd_sel out NUM_SRC*SELW: registered per-source forward select for the instruction now in EX.
REQ-015 busy out 1: any tracking slot is valid.

Function
REQ-016 SHALL keep a shift pipeline of FWD_STAGES+1 slots {valid, rd, lat}; slot 0 = producer in EX, slot k = producer in forwarding stage k.
REQ-017 Issue: at every clk edge, slot 0 SHALL load {1, id_rd, lat'} when id_valid && id_reg_write && !stall && !flush && id_rd != R0; otherwise slot 0 SHALL load valid=0.
REQ-018 lat' SHALL be id_lat clamped to the range 1..FWD_STAGES (0 becomes 1; values above FWD_STAGES become FWD_STAGES).
REQ-019 At every edge, slot k SHALL load slot k-1 for k = 1..FWD_STAGES, regardless of stall; the contents of the last slot are discarded.
REQ-020 R0 SHALL be the address with every trit equal to `T_ZERO; R0 is never tracked, matched, stalled on or forwarded.
REQ-021 Match SHALL require a valid slot and a trit-by-trit equality of all ADDR_TRITS trits between the slot rd and the source address.
REQ-022 For each source s with id_src_used[s] set, j(s) SHALL be the lowest slot index j in 0..FWD_STAGES-1 that matches; lowest index means youngest producer, and the youngest wins on WAW.
REQ-023 stall SHALL be combinational: asserted iff id_valid && !flush && some source s has a match with slot[j(s)].lat > j(s)+1.
REQ-024 When a source has no match, or id_src_used[s]=0, or the source is R0, its select SHALL be 0, meaning the register-file value is used.
REQ-025 At each edge with id_valid && !stall && !flush, ex_fwd_sel[s] SHALL load j(s)+1 (or 0 per REQ-024); otherwise it SHALL load 0.
REQ-026 Flush SHALL invalidate the EX producer: slot 1 loads valid=0 instead of slot 0, and slot 0 loads valid=0.
REQ-027 On flush, slots already at stage 1 or older SHALL shift normally, because those producers have already committed past EX.
REQ-028 Flush SHALL take priority over stall and over issue in the same cycle.
REQ-029 Simultaneous issue and match: an instruction in ID SHALL compare against slots before the edge, and SHALL never match its own id_rd.
REQ-030 busy SHALL be the OR of the valid bits of all slots.

Reset
REQ-031 While rst_n=0, all slot valid bits, rd and lat fields, and ex_fwd_sel SHALL be 0 immediately and asynchronously; stall SHALL be 0 and busy SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL drop all tracked producers; the first edge after release SHALL behave as an empty pipeline.
REQ-033 Reset release SHALL be synchronised externally; the block has no internal reset synchroniser.

Verification
REQ-034 ALU back-to-back: issue rd={0,0,+} with lat=1, then a consumer with rs1={0,0,+} -> stall=0; ex_fwd_sel[0]=1 on the next cycle.
REQ-035 Load-use: issue a load with rd={0,+,-} and lat=2, then a consumer of {0,+,-} -> stall=1 for one cycle, then stall=0 with ex_fwd_sel=2 (FWD_STAGES=2).
REQ-036 WAW priority: producers to {+,0,0} at two consecutive issues (both lat=1), then a consumer -> ex_fwd_sel=1 (youngest), not 2.
REQ-037 R0 and unused sources: producer with rd=R0, or consumer with id_src_used=0 -> stall=0, ex_fwd_sel=0, busy unaffected by R0.
REQ-038 Flush: producer {0,0,-} in EX and flush=1, then a consumer of {0,0,-} -> ex_fwd_sel=0, no stall.
REQ-039 Reset mid-stall: assert rst_n=0 during the load-use stall -> stall=0, busy=0, ex_fwd_sel=0 immediately; after release the same consumer sees ex_fwd_sel=0.
